proc_control_unit: RTL and testbench

Sequencing FSM for the simple processor datapath. Fetches a 16-bit instruction word from din into its instruction register and drives the bus-source selects (immediate, R0..R7, G), register load enables, the A/G latches and the ALU operation, one step per clock. Multi-cycle: 2 steps for moves/NOP, 4 steps for ALU ops; pulses done on the final step.

---
 rtl/proc_ctrl_pkg.sv | 38 +++
 rtl/proc_control_unit_if.sv | 25 ++
 rtl/reg_decoder.sv | 13 +
 rtl/proc_control_unit.sv | 55 +++++
 tb/tb_proc_control_unit.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: shared widths, opcode and step encodings, and field decode helpers
// for the processor control unit.
package proc_ctrl_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int OPC_W = 3;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int OP_LSB = DATA_WIDTH - OPC_W;
    localparam int RX_LSB = OP_LSB - REG_ADDR_W;
    localparam int RY_LSB = RX_LSB - REG_ADDR_W;
    typedef logic [OPC_W-1:0] opcode_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [1:0] alu_op_t;
    localparam opcode_t OP_MV = 3'd0;
    localparam opcode_t OP_MVI = 3'd1;
    localparam opcode_t OP_ADD = 3'd2;
    localparam opcode_t OP_SUB = 3'd3;
    localparam opcode_t OP_AND = 3'd4;
    localparam opcode_t OP_OR = 3'd5;
    localparam opcode_t OP_NOP = 3'd6;
    localparam alu_op_t ALU_ADD = 2'b00;
    localparam alu_op_t ALU_SUB = 2'b01;
    localparam alu_op_t ALU_AND = 2'b10;
    localparam alu_op_t ALU_OR = 2'b11;
    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
    // Only the op/rx/ry fields of the instruction word steer the sequence.
    typedef struct packed {
        opcode_t op;
        reg_addr_t rx;
        reg_addr_t ry;
    } instr_t;
    function automatic logic is_alu(input opcode_t op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    endfunction
    function automatic alu_op_t alu_code(input opcode_t op);
        return op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : op == OP_OR ? ALU_OR : ALU_ADD;
    endfunction
endpackage

// File: rtl/proc_control_unit_if.sv
// proc_control_unit_if: instruction input and datapath control bundle between the
// control unit (master) and the datapath (slave).
interface proc_control_unit_if;
    import proc_ctrl_pkg::*;
    logic run;
    logic [DATA_WIDTH-1:0] din;
    logic ir_in;
    logic imediate_select;
    logic [NUM_REGS-1:0] r_out;
    logic g_select;
    logic [NUM_REGS-1:0] reg_in;
    logic a_in;
    logic g_in;
    alu_op_t alu_op;
    logic busy;
    logic done;
    modport master (
        input run, din,
        output ir_in, imediate_select, r_out, g_select, reg_in, a_in, g_in, alu_op, busy, done
    );
    modport slave (
        output run, din,
        input ir_in, imediate_select, r_out, g_select, reg_in, a_in, g_in, alu_op, busy, done
    );
endinterface

// File: rtl/reg_decoder.sv
// reg_decoder: binary register address to one-hot select, all zero when disabled.
module reg_decoder
    import proc_ctrl_pkg::*;
#(
    parameter int W = REG_ADDR_W
) (
    input  logic en,
    input  logic [W-1:0] addr,
    output logic [2**W-1:0] onehot
);
    localparam int N = 2 ** W;
    assign onehot = en ? N'(1) << addr : '0;
endmodule

// File: rtl/proc_control_unit.sv
// proc_control_unit: T0..T3 sequencer that fetches an instruction and drives the
// bus-source selects, register loads, A/G latches and ALU op one step per clock.
module proc_control_unit
    import proc_ctrl_pkg::*;
(
    input logic clock,
    input logic resetn,
    proc_control_unit_if.master bus
);
    step_t step, step_nxt;
    instr_t ir;
    logic fetch, alu;
    logic src_en, dst_en;
    reg_addr_t src_addr;
    assign fetch = step == T0 && bus.run;
    assign alu = is_alu(ir.op);
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            step <= T0;
            ir <= '0;
        end else begin
            step <= step_nxt;
            if (fetch) ir <= instr_t'(bus.din[DATA_WIDTH-1:RY_LSB]);
        end
    end
    // Moves and NOPs retire in T1; ALU ops walk through T2 and T3.
    always_comb begin
        step_nxt = step == T0 ? (bus.run ? T1 : T0) :
                   step == T1 ? (alu ? T2 : T0) :
                   step == T2 ? T3 : T0;
    end
    always_comb begin
        bus.ir_in = fetch;
        bus.imediate_select = step == T1 && ir.op == OP_MVI;
        bus.g_select = step == T3 && alu;
        bus.a_in = step == T1 && alu;
        bus.g_in = step == T2 && alu;
        bus.alu_op = step == T2 && alu ? alu_code(ir.op) : ALU_ADD;
        src_en = (step == T1 && (ir.op == OP_MV || alu)) || (step == T2 && alu);
        src_addr = step == T1 && alu ? ir.rx : ir.ry;
        dst_en = (step == T1 && (ir.op == OP_MV || ir.op == OP_MVI)) || (step == T3 && alu);
        bus.busy = step != T0;
        bus.done = (step == T1 && !alu) || (step == T3 && alu);
    end
    reg_decoder #(.W(REG_ADDR_W)) u_src (
        .en(src_en),
        .addr(src_addr),
        .onehot(bus.r_out)
    );
    reg_decoder #(.W(REG_ADDR_W)) u_dst (
        .en(dst_en),
        .addr(ir.rx),
        .onehot(bus.reg_in)
    );
endmodule

// File: tb/tb_proc_control_unit.sv
// tb_proc_control_unit: vector table, reset corner case and random stream checked
// against an instruction-level model that expands each fetch into per-step outputs.
module tb_proc_control_unit;
    import proc_ctrl_pkg::*;
    typedef struct packed {
        logic ir_in;
        logic imm;
        logic [7:0] r_out;
        logic g_sel;
        logic [7:0] reg_in;
        logic a_in;
        logic g_in;
        logic [1:0] alu_op;
        logic busy;
        logic done;
    } out_t;
    typedef struct {
        logic run;
        logic [15:0] din;
        out_t exp;
    } vec_t;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int errors = 0;
    int checks = 0;
    out_t q[$];
    vec_t tv[18];
    always #5 clock = ~clock;
    proc_control_unit_if b ();
    proc_control_unit dut (.clock(clock), .resetn(resetn), .bus(b));

    function automatic out_t mk(input logic ir, input logic imm, input logic [7:0] r, input logic g,
                                input logic [7:0] rg, input logic a, input logic gi,
                                input logic [1:0] op, input logic busy, input logic done);
        return {ir, imm, r, g, rg, a, gi, op, busy, done};
    endfunction

    function automatic out_t actual();
        return {b.ir_in, b.imediate_select, b.r_out, b.g_select, b.reg_in, b.a_in, b.g_in,
                b.alu_op, b.busy, b.done};
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t a;
        int src;
        a = actual();
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, a, exp, $time);
        end
        src = int'(a.imm) + int'(a.g_sel) + $countones(a.r_out);
        checks++;
        if (src > 1 || !$onehot0(a.reg_in)) begin
            errors++;
            $display("FAIL %s_onehot: sources=%0d reg_in=%b required <=1 and onehot0", name, src, a.reg_in);
        end
    endtask

    // One instruction becomes the list of outputs expected in its T1.. steps.
    task automatic expand(input logic [15:0] w);
        logic [2:0] op;
        logic [7:0] x, y;
        op = w[15:13];
        x = 8'd1 << w[12:10];
        y = 8'd1 << w[9:7];
        case (op)
            3'd0: q.push_back(mk(0, 0, y, 0, x, 0, 0, 2'b00, 1, 1));
            3'd1: q.push_back(mk(0, 1, 0, 0, x, 0, 0, 2'b00, 1, 1));
            3'd2, 3'd3, 3'd4, 3'd5: begin
                q.push_back(mk(0, 0, x, 0, 0, 1, 0, 2'b00, 1, 0));
                q.push_back(mk(0, 0, y, 0, 0, 0, 1, op == 3'd2 ? 2'b00 : op == 3'd3 ? 2'b01 :
                                                    op == 3'd4 ? 2'b10 : 2'b11, 1, 0));
                q.push_back(mk(0, 0, 0, 1, x, 0, 0, 2'b00, 1, 1));
            end
            default: q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1));
        endcase
    endtask

    task automatic model_exp(input logic run, input logic [15:0] din, output out_t e);
        if (q.size() > 0) begin
            e = q.pop_front();
        end else begin
            e = mk(run, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
            if (run) expand(din);
        end
    endtask

    task automatic apply(input string name, input logic run, input logic [15:0] din, input out_t exp);
        b.run = run;
        b.din = din;
        @(negedge clock);
        check(name, exp);
        @(posedge clock);
        #1;
    endtask

    task automatic apply_model(input string name, input logic run, input logic [15:0] din);
        out_t e;
        model_exp(run, din, e);
        apply(name, run, din, e);
    endtask

    initial begin
        tv[0]  = '{1'b1, 16'h3400, mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 2'b00, 0, 0)};
        tv[1]  = '{1'b0, 16'h1234, mk(0, 1, 8'h00, 0, 8'h20, 0, 0, 2'b00, 1, 1)};
        tv[2]  = '{1'b0, 16'h0000, mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 2'b00, 0, 0)};
        tv[3]  = '{1'b1, 16'h0B80, mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 2'b00, 0, 0)};
        tv[4]  = '{1'b0, 16'h0000, mk(0, 0, 8'h80, 0, 8'h04, 0, 0, 2'b00, 1, 1)};
        tv[5]  = '{1'b1, 16'h6600, mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 2'b00, 0, 0)};
        tv[6]  = '{1'b1, 16'h0000, mk(0, 0, 8'h02, 0, 8'h00, 1, 0, 2'b00, 1, 0)};
        tv[7]  = '{1'b0, 16'h0000, mk(0, 0, 8'h10, 0, 8'h00, 0, 1, 2'b01, 1, 0)};
        tv[8]  = '{1'b1, 16'hE000, mk(0, 0, 8'h00, 1, 8'h02, 0, 0, 2'b00, 1, 1)};
        tv[9]  = '{1'b1, 16'hE000, mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 2'b00, 0, 0)};
        tv[10] = '{1'b1, 16'h0B80, mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 2'b00, 1, 1)};
        tv[11] = '{1'b1, 16'h0B80, mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 2'b00, 0, 0)};
        tv[12] = '{1'b0, 16'h0000, mk(0, 0, 8'h80, 0, 8'h04, 0, 0, 2'b00, 1, 1)};
        tv[13] = '{1'b1, 16'h4D80, mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 2'b00, 0, 0)};
        tv[14] = '{1'b1, 16'hFFFF, mk(0, 0, 8'h08, 0, 8'h00, 1, 0, 2'b00, 1, 0)};
        tv[15] = '{1'b0, 16'h0000, mk(0, 0, 8'h08, 0, 8'h00, 0, 1, 2'b00, 1, 0)};
        tv[16] = '{1'b0, 16'h0000, mk(0, 0, 8'h00, 1, 8'h08, 0, 0, 2'b00, 1, 1)};
        tv[17] = '{1'b0, 16'h0000, mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 2'b00, 0, 0)};
        b.run = 1'b0;
        b.din = '0;
        #12;
        check("reset_idle", mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        b.run = 1'b1;
        #1;
        check("reset_ir_in_follows_run", mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        b.run = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 18; i++) apply($sformatf("vec%0d", i), tv[i].run, tv[i].din, tv[i].exp);
        q.delete();
        for (int i = 0; i < 400; i++)
            apply_model($sformatf("rand%0d", i), $urandom_range(0, 2) != 0, 16'($urandom));
        while (q.size() > 0) apply_model("drain", 1'b0, 16'h0000);
        apply("rst_fetch", 1'b1, 16'h4500, mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 2'b00, 0, 0));
        apply("rst_t1", 1'b0, 16'h0000, mk(0, 0, 8'h02, 0, 8'h00, 1, 0, 2'b00, 1, 0));
        #1;
        check("rst_t2", mk(0, 0, 8'h04, 0, 8'h00, 0, 1, 2'b00, 1, 0));
        resetn = 1'b0;
        #1;
        check("rst_async_drop", mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++)
            apply($sformatf("rst_after%0d", i), 1'b0, 16'h0000, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
